// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_seq_pkg.sv
// Package for the sequenced tie-off bank.
// Contents:
//   state_t     - sequencer state {IDLE, UP, ON, DOWN}, 2 bits
//   clog2_min1  - counter width helper that never returns 0
//   *_MIN/*_MAX - legal parameter ranges checked at elaboration
package gf180mcu_fd_sc_mcu7t5v0__tie_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    localparam int NCH_MIN     = 1;
    localparam int NCH_MAX     = 32;
    localparam int STAGGER_MIN = 1;

    // Width needed to hold values 0..n-1, at least one bit so that a
    // degenerate range still yields a legal vector.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_seq_if.sv
// Control/status bundle of the sequenced tie-off bank.
// Signals:
//   EN    - 1 = release the bank toward TIE_VAL, 0 = return to SAFE_VAL
//   HOLD  - 1 = freeze the sequencer; EN is ignored
//   Z     - NCH registered tie outputs
//   READY - all channels released (state ON)
//   BUSY  - sequencing in progress (state UP or DOWN)
// There is no handshake: EN/HOLD are levels sampled on every rising CLK
// edge, and Z/READY/BUSY are registered levels valid after every edge.
// Modports: master drives EN/HOLD (controller side), slave is the bank.
interface gf180mcu_fd_sc_mcu7t5v0__tie_seq_if #(
    parameter int NCH = 4
);
    logic           EN;
    logic           HOLD;
    logic [NCH-1:0] Z;
    logic           READY;
    logic           BUSY;

    modport master (
        output EN,
        output HOLD,
        input  Z,
        input  READY,
        input  BUSY
    );

    modport slave (
        input  EN,
        input  HOLD,
        output Z,
        output READY,
        output BUSY
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_seq_timer.sv
// Stagger timer: modulo-STAGGER counter pacing channel transitions.
// Ports:
//   CLK, RST - clock, asynchronous active-high reset
//   clr_i    - restart the count at 0 (ignored while hold_i is set)
//   hold_i   - freeze the count
//   tick_o   - count is at STAGGER-1 and not held: a transition is due
module gf180mcu_fd_sc_mcu7t5v0__tie_seq_timer
    import gf180mcu_fd_sc_mcu7t5v0__tie_seq_pkg::*;
#(
    parameter int STAGGER = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam int            T_W  = clog2_min1(STAGGER);
    localparam logic [T_W-1:0] LAST = T_W'(STAGGER - 1);

    logic [T_W-1:0] t_q;
    logic [T_W-1:0] t_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    // The counter only wraps on the tick; with STAGGER=1 it stays at 0.
    always_comb begin
        t_d = t_q;
        if (!hold_i) begin
            if (clr_i || (t_q == LAST)) begin
                t_d = '0;
            end else begin
                t_d = t_q + T_W'(1);
            end
        end
    end

    assign tick_o = (t_q == LAST) && !hold_i;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_seq.sv
// Sequenced tie-off bank. Outputs power up at SAFE_VAL; on EN they are
// released to TIE_VAL one channel at a time, STAGGER clocks apart, and
// on !EN they return to SAFE_VAL in reverse order. At most one Z bit
// changes per clock.
// Ports:
//   CLK         - clock, rising edge
//   RST         - asynchronous active-high reset (Z returns to SAFE_VAL)
//   bus         - slave side of the control/status bundle (EN, HOLD, Z,
//                 READY, BUSY)
//   dbg_state_o - current sequencer state
module gf180mcu_fd_sc_mcu7t5v0__tie_seq
    import gf180mcu_fd_sc_mcu7t5v0__tie_seq_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             STAGGER  = 8,
    parameter logic [NCH-1:0] TIE_VAL  = {NCH{1'b1}},
    parameter logic [NCH-1:0] SAFE_VAL = {NCH{1'b0}}
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    gf180mcu_fd_sc_mcu7t5v0__tie_seq_if.slave        bus,
    output state_t                                   dbg_state_o
);
    localparam int              RC_W   = clog2_min1(NCH + 1);
    localparam logic [RC_W-1:0] RC_NCH = RC_W'(NCH);

    generate
        if (NCH < NCH_MIN || NCH > NCH_MAX || STAGGER < STAGGER_MIN) begin : g_bad_param
            $error("tie_seq: NCH must be 1..32 and STAGGER >= 1");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [NCH-1:0]  z_q, z_d;
    logic            ready_q;
    logic            busy_q;
    logic            clr;
    logic            tick;

    gf180mcu_fd_sc_mcu7t5v0__tie_seq_timer #(
        .STAGGER (STAGGER)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr_i  (clr),
        .hold_i (bus.HOLD),
        .tick_o (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            rc_q    <= '0;
            z_q     <= SAFE_VAL;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            z_q     <= z_d;
            ready_q <= (state_d == ON);
            busy_q  <= (state_d == UP) || (state_d == DOWN);
        end
    end

    // A direction change wins over a simultaneous tick: rc is kept and
    // the timer restarts, so the first move after a reversal is a full
    // STAGGER clocks away. The rc guards only matter when a reversal
    // happens at an end stop (e.g. UP entered from DOWN with rc=NCH).
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        clr     = 1'b0;
        if (!bus.HOLD) begin
            case (state_q)
                IDLE: begin
                    clr = 1'b1;
                    if (bus.EN) begin
                        state_d = UP;
                    end
                end
                UP: begin
                    if (!bus.EN) begin
                        state_d = DOWN;
                        clr     = 1'b1;
                    end else if (tick) begin
                        if (rc_q != RC_NCH) begin
                            rc_d = rc_q + RC_W'(1);
                        end
                        if (rc_d == RC_NCH) begin
                            state_d = ON;
                        end
                    end
                end
                ON: begin
                    clr = 1'b1;
                    if (!bus.EN) begin
                        state_d = DOWN;
                    end
                end
                DOWN: begin
                    if (bus.EN) begin
                        state_d = UP;
                        clr     = 1'b1;
                    end else if (tick) begin
                        if (rc_q != '0) begin
                            rc_d = rc_q - RC_W'(1);
                        end
                        if (rc_d == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Channels below the released count drive TIE, the rest SAFE.
        z_d = SAFE_VAL;
        for (int i = 0; i < NCH; i++) begin
            z_d[i] = (RC_W'(i) < rc_d) ? TIE_VAL[i] : SAFE_VAL[i];
        end
    end

    assign bus.Z       = z_q;
    assign bus.READY   = ready_q;
    assign bus.BUSY    = busy_q;
    assign dbg_state_o = state_q;

endmodule
